// File: rtl/fc_param_loader_if.sv
// Bundles the loader's two bus-side connections: the synchronous-read parameter
// memory port and the FC layer port. The master modport is the loader side; the
// slave modport is the memory/FC-layer side.
// Ports carried:
//    mem_rd, mem_addr  : read strobe and address, master -> memory
//    mem_data          : read data, memory -> master, valid one cycle after mem_rd
//    weights, biases   : parameter arrays, master -> FC layer
//    fc_reset          : one-cycle FC layer reset pulse, master -> FC layer
//    fc_enable         : FC layer enable, master -> FC layer
//    fc_finished       : FC layer completion flag, FC layer -> master
interface fc_param_loader_if #(
   parameter int numNodesIn  = 5,
   parameter int numNodesOut = 3,
   parameter int ADDR_W      = 16
);
   logic                                         mem_rd;
   logic [ADDR_W-1:0]                            mem_addr;
   logic [15:0]                                  mem_data;
   logic [numNodesIn*numNodesOut-1:0][15:0]      weights;
   logic [numNodesOut-1:0][15:0]                 biases;
   logic                                         fc_reset;
   logic                                         fc_enable;
   logic                                         fc_finished;

   modport master (
      output mem_rd, mem_addr, weights, biases, fc_reset, fc_enable,
      input  mem_data, fc_finished
   );

   modport slave (
      input  mem_rd, mem_addr, weights, biases, fc_reset, fc_enable,
      output mem_data, fc_finished
   );
endinterface

// File: rtl/fc_param_loader.sv
// Purpose: load W weights then B biases from parameter memory into the FC layer arrays, pulse FC reset, run FC until finished.
// Latency: start -> fc_enable is N+3 cycles (N = W+B reads); done pulses the cycle after fc_finished is sampled in RUN.
// Backpressure: none; start is ignored while busy, memory must return data exactly one cycle after mem_rd.
// Ports:
//    clk, reset  : clock and synchronous active-high reset
//    start       : begin load+run, sampled only in IDLE
//    busy, done  : busy in every state but IDLE; done is a one-cycle completion pulse
//    bus         : memory read port and FC layer port (fc_param_loader_if.master)
module fc_param_loader #(
   parameter int                numNodesIn  = 5,
   parameter int                numNodesOut = 3,
   parameter int                ADDR_W      = 16,
   parameter logic [ADDR_W-1:0] BASE_ADDR   = '0
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                start,
   output logic                busy,
   output logic                done,
   fc_param_loader_if.master   bus
);

   localparam int W  = numNodesIn * numNodesOut;
   localparam int B  = numNodesOut;
   localparam int N  = W + B;
   localparam int CW = $clog2(N + 1);
   localparam logic [CW-1:0] LAST_IDX = CW'(N - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_FETCH,
      S_DRAIN,
      S_FCRST,
      S_RUN,
      S_DONE
   } state_t;

   state_t           state_q, state_d;
   logic [CW-1:0]    rd_idx_q, rd_idx_d;
   logic [CW-1:0]    cap_idx_q;
   logic             cap_vld_q;
   logic [W-1:0][15:0] weights_q;
   logic [B-1:0][15:0] biases_q;

   logic mem_rd, fc_reset, fc_enable;

   // State and read index
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= S_IDLE;
         rd_idx_q <= '0;
      end else begin
         state_q  <= state_d;
         rd_idx_q <= rd_idx_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      rd_idx_d  = rd_idx_q;
      mem_rd    = 1'b0;
      fc_reset  = 1'b0;
      fc_enable = 1'b0;
      busy      = 1'b1;
      done      = 1'b0;
      case (state_q)
         S_IDLE: begin
            busy     = 1'b0;
            rd_idx_d = '0;
            if (start) state_d = S_FETCH;
         end
         S_FETCH: begin
            mem_rd   = 1'b1;
            rd_idx_d = rd_idx_q + 1'b1;
            if (rd_idx_q == LAST_IDX) begin
               // Parking the index at zero keeps mem_addr at BASE_ADDR outside FETCH.
               rd_idx_d = '0;
               state_d  = S_DRAIN;
            end
         end
         // The last word is captured during this cycle by the capture pipeline.
         S_DRAIN: state_d = S_FCRST;
         S_FCRST: begin
            fc_reset = 1'b1;
            state_d  = S_RUN;
         end
         S_RUN: begin
            fc_enable = 1'b1;
            if (bus.fc_finished) state_d = S_DONE;
         end
         S_DONE: begin
            done    = 1'b1;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Capture pipeline: one stage behind the read index, matching the memory's
   // one-cycle read latency. Clearing cap_vld_q on reset discards any in-flight word.
   always_ff @(posedge clk) begin
      if (reset) begin
         cap_vld_q <= 1'b0;
         cap_idx_q <= '0;
         weights_q <= '0;
         biases_q  <= '0;
      end else begin
         cap_vld_q <= mem_rd;
         cap_idx_q <= rd_idx_q;
         for (int k = 0; k < W; k++) begin
            if (cap_vld_q && cap_idx_q == CW'(k)) weights_q[k] <= bus.mem_data;
         end
         for (int j = 0; j < B; j++) begin
            if (cap_vld_q && cap_idx_q == CW'(W + j)) biases_q[j] <= bus.mem_data;
         end
      end
   end

   assign bus.mem_rd    = mem_rd;
   assign bus.mem_addr  = BASE_ADDR + ADDR_W'(rd_idx_q);
   assign bus.weights   = weights_q;
   assign bus.biases    = biases_q;
   assign bus.fc_reset  = fc_reset;
   assign bus.fc_enable = fc_enable;

endmodule
